// File: rtl/vec_regfile_masked_if.sv
// Bus bundle for vec_regfile_masked: two masked write ports, two registered
// read ports and the broadcast-fill control/status.
interface vec_regfile_masked_if #(
  parameter int NUM_REGS = 8,
  parameter int VLEN     = 512,
  parameter int ELEN     = 32
);
  localparam int LANES  = VLEN / ELEN;
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              wEnable1;
  logic [ADDR_W-1:0] wAdd1;
  logic [VLEN-1:0]   input1;
  logic [LANES-1:0]  wMask1;
  logic              wEnable2;
  logic [ADDR_W-1:0] wAdd2;
  logic [VLEN-1:0]   input2;
  logic [LANES-1:0]  wMask2;
  logic [ADDR_W-1:0] rAdd1;
  logic [VLEN-1:0]   out1;
  logic [ADDR_W-1:0] rAdd2;
  logic [VLEN-1:0]   out2;
  logic              fill_start;
  logic [ELEN-1:0]   fill_value;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output wEnable1, wAdd1, input1, wMask1,
    output wEnable2, wAdd2, input2, wMask2,
    output rAdd1, rAdd2, fill_start, fill_value,
    input  out1, out2, fill_busy, fill_done
  );

  modport slave (
    input  wEnable1, wAdd1, input1, wMask1,
    input  wEnable2, wAdd2, input2, wMask2,
    input  rAdd1, rAdd2, fill_start, fill_value,
    output out1, out2, fill_busy, fill_done
  );
endinterface

// File: rtl/vec_regfile_masked.sv
// Vector register file: two lane-masked write ports, two registered read ports
// with write-first bypass, and a one-register-per-cycle broadcast-fill sequencer.
module vec_regfile_masked #(
  parameter int NUM_REGS = 8,
  parameter int VLEN     = 512,
  parameter int ELEN     = 32
) (
  input  logic clk,
  input  logic reset,
  vec_regfile_masked_if.slave bus
);
  localparam int LANES  = VLEN / ELEN;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ELEN-1:0]   fill_val_q, fill_val_d;
  logic              port_en;
  logic              fill_wr;

  logic [NUM_REGS-1:0][LANES-1:0][ELEN-1:0] regs_q, regs_d;
  logic [VLEN-1:0] out1_q, out1_d, out2_q, out2_d;

  // Next contents of every register; reads use these, giving write-first bypass.
  // Out-of-range write addresses match no register and are dropped here.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic sel1, sel2, sel_fill;
    assign sel1     = port_en & bus.wEnable1 & (bus.wAdd1 == ADDR_W'(gi));
    assign sel2     = port_en & bus.wEnable2 & (bus.wAdd2 == ADDR_W'(gi));
    assign sel_fill = fill_wr & (cnt_q == ADDR_W'(gi));
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      assign regs_d[gi][gl] =
          sel_fill                 ? fill_val_q :
          (sel2 & bus.wMask2[gl])  ? bus.input2[gl*ELEN +: ELEN] :
          (sel1 & bus.wMask1[gl])  ? bus.input1[gl*ELEN +: ELEN] :
                                     regs_q[gi][gl];
    end
  end

  always_comb begin
    out1_d = '0;
    out2_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.rAdd1 == ADDR_W'(r)) out1_d = regs_d[r];
      if (bus.rAdd2 == ADDR_W'(r)) out2_d = regs_d[r];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    port_en    = 1'b0;
    fill_wr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        port_en = 1'b1;
        if (bus.fill_start) begin
          fill_val_d = bus.fill_value;
          cnt_d      = '0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        fill_wr = 1'b1;
        if (cnt_q == LAST_REG) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
      regs_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      regs_q     <= regs_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
    end
  end

  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.fill_busy = (state_q != S_IDLE);
  assign bus.fill_done = (state_q == S_DONE);
endmodule

// File: doc/vec_regfile_masked.md
Name: vec_regfile_masked

Overview:
Parametrised vector register file for the vector datapath, successor to the fixed 4x512 two-write/one-read file. Adds configurable depth, width and element size, and per-element write masks on two write ports. Provides two registered read ports with write-first bypass and a synchronous broadcast-fill sequencer that replaces asynchronous set/clear loops. Sits between the vector ALU write-back and operand fetch.

Parameters:
NUM_REGS, 8, number of vector registers (2..64, power of 2 not required)
VLEN, 512, bits per vector register
ELEN, 32, bits per element; VLEN % ELEN == 0; LANES = VLEN/ELEN (derived)
ADDR_W, $clog2(NUM_REGS), register address width (derived localparam)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wEnable1  input  1  write port 1 enable
wAdd1  input  ADDR_W  write port 1 address
input1  input  VLEN  write port 1 data
wMask1  input  LANES  write port 1 per-element enable (bit k -> bits [k*ELEN +: ELEN])
wEnable2, wAdd2, input2, wMask2  input  1/ADDR_W/VLEN/LANES  write port 2, same meaning
rAdd1  input  ADDR_W  read port 1 address
out1  output  VLEN  read port 1 data, registered
rAdd2  input  ADDR_W  read port 2 address
out2  output  VLEN  read port 2 data, registered
fill_start  input  1  request broadcast fill of every register
fill_value  input  ELEN  element replicated into all lanes of all registers
fill_busy  output  1  fill sequencer active
fill_done  output  1  one-cycle pulse when fill completes

Behaviour:
- Reset (reset=1 at posedge): all registers = 0; out1/out2 = 0; fill_busy = 0; fill_done = 0; FSM -> IDLE; counter = 0. Reset overrides every other input in the same cycle.
- Data is raw bits; no sign handling inside the block.
- Write (IDLE only): on posedge, if wEnableN and wAdd < NUM_REGS, each lane k with wMaskN[k]=1 takes inputN lane k; unmasked lanes hold.
- Port conflict: same address, both enabled: port 2 wins on lanes set in both masks; lanes set in only one mask take that port's data (merge).
- wAdd >= NUM_REGS: write ignored. rAdd >= NUM_REGS: read returns 0.
- Read latency 1: outN at cycle t+1 = contents of rAdd at cycle t after the cycle-t writes are applied (write-first bypass, per lane, using the same conflict rule). An unwritten/masked-off lane returns the old value.
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE: fill_start=1 -> capture fill_value, counter = 0, go to FILL. Writes presented in the same cycle are still performed.
  - FILL: each cycle, register[counter] = {LANES{fill_value_captured}}, counter++. After writing NUM_REGS-1 -> DONE. Exactly NUM_REGS cycles.
  - DONE: fill_done = 1 for this single cycle; -> IDLE.
  - fill_busy = 1 in FILL and DONE, 0 in IDLE.
  - While fill_busy: wEnable1/2 ignored (no write, no bypass); fill_start ignored.
  - Fill writes bypass to reads like normal writes.
- Reset mid-fill: abort immediately, all registers 0, no fill_done pulse.
- Back-to-back: fill_start asserted in the cycle the FSM returns to IDLE starts a new fill.

Test Plan:
- Reset/basic (8x512, ELEN 32): reset 2 cycles, read r0..r7 -> all 0; write r3 = all-ones, mask 0xFFFF; read r3 next cycle -> 512'hFF..FF; r2 still 0.
- Mask merge: r5 = 0; port1 r5 data A5A5A5A5 per lane, mask 0x00FF; port2 r5 data 3C3C3C3C per lane, mask 0xFF0F; read -> lanes 0-3 = 3C3C3C3C, lanes 4-7 = A5A5A5A5, lanes 8-15 = 3C3C3C3C.
- Write-first bypass: in a single cycle write r1 = 0x1234 in lane 0 (mask 0x0001), rAdd1 = rAdd2 = 1 -> out1 = out2 show lane 0 = 0x00001234 on the next cycle; other lanes show the old value.
- Fill: fill_start with fill_value = 0xDEADBEEF -> fill_busy high for 9 cycles (8 FILL + DONE); fill_done pulses once in cycle 9; every lane of r0..r7 = DEADBEEF. A wEnable1 to r0 during FILL is not applied.
- Reset mid-fill: reset in the 4th FILL cycle -> next cycle: busy = 0, all registers 0, fill_done never pulses.
- Out-of-range (NUM_REGS = 6): write wAdd = 7 -> no register changes; rAdd = 6 -> out = 0.
